// File: rtl/lbuf_mrd_req_pkg.sv
// Shared definitions for the lbuf MRd requester.
// Contents:
//   state_e   - requester FSM states; the top module exposes the current
//               state on its dbg_state port
//   FMT_*     - TLP fmt codes for a memory read with no data (3DW / 4DW header)
//   TYPE_MRD  - TLP type code for a memory read
//   TREM_*    - trn_trem_n encodings (both DWs valid / upper DW only)
//   mrrs_dw() - decodes the PCIe max-read-request-size field to DWs and
//               clamps the result to a local cap
package lbuf_mrd_req_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CALC = 3'd1,
    ST_WAIT = 3'd2,
    ST_HDR0 = 3'd3,
    ST_HDR1 = 3'd4,
    ST_DONE = 3'd5
  } state_e;

  localparam logic [1:0]  FMT_MRD_3DW = 2'b00;
  localparam logic [1:0]  FMT_MRD_4DW = 2'b01;
  localparam logic [4:0]  TYPE_MRD    = 5'b00000;
  localparam logic [7:0]  TREM_BOTH   = 8'h00;
  localparam logic [7:0]  TREM_UPPER  = 8'h0F;
  localparam logic [10:0] DW_PER_4KB  = 11'd1024;

  // MRRS encoding n means 128<<n bytes, which is 32<<n DWs. The encodings
  // 6 and 7 are reserved; they are treated as the 4KB maximum, and the cap
  // then limits them.
  function automatic logic [10:0] mrrs_dw(input logic [2:0]  enc,
                                          input logic [10:0] cap_dw);
    logic [10:0] dw;
    if (enc > 3'd5) dw = 11'd1024;
    else            dw = 11'd32 << enc;
    return (dw < cap_dw) ? dw : cap_dw;
  endfunction

endpackage

// File: rtl/lbuf_mrd_req_chunk_calc.sv
// Combinational sizing of the next MRd.
// Ports:
//   addr_dw_off  in  10  cur_addr[11:2], the DW offset inside the current 4KB page
//   rem_dw       in  33  DWs still to be requested
//   mrrs_enc     in  3   PCIe MRRS encoding
//   chunk_dw     out 11  min(effective MRRS in DWs, rem_dw, DWs to the next 4KB boundary)
module lbuf_mrd_req_chunk_calc
  import lbuf_mrd_req_pkg::*;
#(
  parameter int MAX_RD_BYTES = 512
) (
  input  logic [9:0]  addr_dw_off,
  input  logic [32:0] rem_dw,
  input  logic [2:0]  mrrs_enc,
  output logic [10:0] chunk_dw
);

  localparam logic [10:0] CAP_DW = 11'(MAX_RD_BYTES / 4);

  logic [10:0] mrrs_lim;
  logic [10:0] bnd_dw;
  logic [10:0] lim;

  always_comb begin
    mrrs_lim = mrrs_dw(mrrs_enc, CAP_DW);
    // An offset of 0 gives 1024: a whole page is available.
    bnd_dw   = DW_PER_4KB - {1'b0, addr_dw_off};
    lim      = (mrrs_lim < bnd_dw) ? mrrs_lim : bnd_dw;
    chunk_dw = (rem_dw < {22'd0, lim}) ? rem_dw[10:0] : lim;
  end

endmodule

// File: rtl/lbuf_mrd_req.sv
// Requester side of the lbuf pull. While rd_lbuf is high, the block issues
// 64-bit MRd TLPs on the Virtex-5 TRN transmit bus. Together the TLPs cover
// lbuf_addr .. lbuf_addr + lbuf_len*8. The block paces itself against a DW
// credit budget; completions (cpl_rcved/cpl_dws) give credit back.
// Ports:
//   clk, rst_n           TRN clock; asynchronous active-low reset
//   rd_lbuf              level request; lbuf_addr/lbuf_len are stable while it is high
//   lbuf_addr            4KB-aligned byte address
//   lbuf_len             length in QWs (a nonzero multiple of 16)
//   rd_lbuf_done         every MRd of the lbuf has been accepted; held until rd_lbuf drops
//   cpl_rcved, cpl_dws   completion strobe and payload DWs (0 means 1024)
//   cfg_completer_id     requester ID placed in DW1
//   cfg_max_rd_req_size  PCIe MRRS encoding
//   trn_tbuf_av          bit 0: a non-posted buffer is available
//   trn_tdst_rdy_n       core ready (active low)
//   trn_td/trn_trem_n/trn_tsof_n/trn_teof_n/trn_tsrc_rdy_n  TRN transmit outputs
//   dbg_state            current FSM state
//
// Handshake: a beat transfers on a rising edge where trn_tsrc_rdy_n and
// trn_tdst_rdy_n are both low. While a beat is offered and not accepted,
// trn_td, trn_trem_n, trn_tsof_n and trn_teof_n do not change. Once the first
// beat of a TLP is offered, trn_tsrc_rdy_n stays low until the second beat is
// accepted.
module lbuf_mrd_req
  import lbuf_mrd_req_pkg::*;
#(
  parameter int MAX_RD_BYTES       = 512,
  parameter int MAX_OUTSTANDING_DW = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rd_lbuf,
  input  logic [63:0] lbuf_addr,
  input  logic [31:0] lbuf_len,
  output logic        rd_lbuf_done,
  input  logic        cpl_rcved,
  input  logic [9:0]  cpl_dws,
  input  logic [15:0] cfg_completer_id,
  input  logic [2:0]  cfg_max_rd_req_size,
  input  logic [3:0]  trn_tbuf_av,
  input  logic        trn_tdst_rdy_n,
  output logic [63:0] trn_td,
  output logic [7:0]  trn_trem_n,
  output logic        trn_tsof_n,
  output logic        trn_teof_n,
  output logic        trn_tsrc_rdy_n,
  output state_e      dbg_state
);

  localparam logic [11:0] BUDGET_DW = 12'(MAX_OUTSTANDING_DW);

  state_e      state_q,    state_d;
  logic [63:0] cur_addr_q, cur_addr_d;
  logic [32:0] rem_dw_q,   rem_dw_d;
  logic [10:0] chunk_dw_q, chunk_dw_d;
  logic [4:0]  tag_q,      tag_d;
  logic [10:0] outst_q,    outst_d;
  logic        done_q,     done_d;
  logic [63:0] td_q,       td_d;
  logic [7:0]  trem_q,     trem_d;
  logic        sof_n_q,    sof_n_d;
  logic        eof_n_q,    eof_n_d;
  logic        src_n_q,    src_n_d;

  logic [10:0] calc_dw;
  logic        use_4dw;
  logic [31:0] hdr_dw0;
  logic [31:0] hdr_dw1;
  logic [63:0] beat1;
  logic        hdr1_accept;
  logic [11:0] outst_add;
  logic [11:0] outst_sub;
  logic [11:0] outst_sum;
  logic        out_underflow;
  logic        budget_ok;
  logic        unused_tbuf;

  // Only the non-posted buffer bit matters for reads.
  assign unused_tbuf = ^trn_tbuf_av[3:1];

  lbuf_mrd_req_chunk_calc #(
    .MAX_RD_BYTES (MAX_RD_BYTES)
  ) u_chunk_calc (
    .addr_dw_off (cur_addr_q[11:2]),
    .rem_dw      (rem_dw_q),
    .mrrs_enc    (cfg_max_rd_req_size),
    .chunk_dw    (calc_dw)
  );

  // Header fields are built from registers that do not change while a TLP
  // is in flight. This keeps both beats stable under backpressure.
  always_comb begin
    use_4dw = |cur_addr_q[63:32];
    hdr_dw0 = {1'b0, (use_4dw ? FMT_MRD_4DW : FMT_MRD_3DW), TYPE_MRD,
               1'b0, 3'b000, 4'b0000, 1'b0, 1'b0, 2'b00, 2'b00,
               chunk_dw_q[9:0]};
    hdr_dw1 = {cfg_completer_id, 3'b000, tag_q, 4'hF, 4'hF};
    if (use_4dw) beat1 = {cur_addr_q[63:32], cur_addr_q[31:2], 2'b00};
    else         beat1 = {cur_addr_q[31:2], 2'b00, 32'h0000_0000};
  end

  // Outstanding DW accounting. A request and a completion in the same cycle
  // net out. Underflow saturates at zero.
  always_comb begin
    hdr1_accept   = (state_q == ST_HDR1) && !trn_tdst_rdy_n;
    outst_add     = hdr1_accept ? {1'b0, chunk_dw_q} : 12'd0;
    if (!cpl_rcved)         outst_sub = 12'd0;
    else if (cpl_dws == '0) outst_sub = 12'd1024;
    else                    outst_sub = {2'b00, cpl_dws};
    outst_sum     = {1'b0, outst_q} + outst_add;
    out_underflow = outst_sum < outst_sub;
    outst_d       = out_underflow ? 11'd0 : 11'(outst_sum - outst_sub);
    budget_ok     = ({1'b0, outst_q} + {1'b0, chunk_dw_q}) <= BUDGET_DW;
  end

  always_comb begin
    state_d    = state_q;
    cur_addr_d = cur_addr_q;
    rem_dw_d   = rem_dw_q;
    chunk_dw_d = chunk_dw_q;
    tag_d      = tag_q;
    done_d     = done_q;
    td_d       = td_q;
    trem_d     = trem_q;
    sof_n_d    = sof_n_q;
    eof_n_d    = eof_n_q;
    src_n_d    = src_n_q;
    case (state_q)
      ST_IDLE: begin
        done_d = 1'b0;
        if (rd_lbuf) begin
          cur_addr_d = lbuf_addr;
          rem_dw_d   = {lbuf_len, 1'b0};
          state_d    = ST_CALC;
        end
      end
      ST_CALC: begin
        chunk_dw_d = calc_dw;
        state_d    = ST_WAIT;
      end
      ST_WAIT: begin
        // Once the request is withdrawn, no new TLP starts.
        if (!rd_lbuf) begin
          state_d = ST_IDLE;
        end else if (budget_ok && trn_tbuf_av[0]) begin
          td_d    = {hdr_dw0, hdr_dw1};
          trem_d  = TREM_BOTH;
          sof_n_d = 1'b0;
          eof_n_d = 1'b1;
          src_n_d = 1'b0;
          state_d = ST_HDR0;
        end
      end
      ST_HDR0: begin
        if (!trn_tdst_rdy_n) begin
          td_d    = beat1;
          trem_d  = use_4dw ? TREM_BOTH : TREM_UPPER;
          sof_n_d = 1'b1;
          eof_n_d = 1'b0;
          state_d = ST_HDR1;
        end
      end
      ST_HDR1: begin
        if (hdr1_accept) begin
          td_d       = '0;
          trem_d     = TREM_BOTH;
          eof_n_d    = 1'b1;
          src_n_d    = 1'b1;
          cur_addr_d = cur_addr_q + {51'd0, chunk_dw_q, 2'b00};
          rem_dw_d   = rem_dw_q - {22'd0, chunk_dw_q};
          tag_d      = tag_q + 5'd1;
          // A withdrawn request never reports done, even on its last TLP.
          if (!rd_lbuf) begin
            state_d = ST_IDLE;
          end else if (rem_dw_d == '0) begin
            done_d  = 1'b1;
            state_d = ST_DONE;
          end else begin
            state_d = ST_CALC;
          end
        end
      end
      ST_DONE: begin
        if (!rd_lbuf) begin
          done_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cur_addr_q <= '0;
      rem_dw_q   <= '0;
      chunk_dw_q <= '0;
      tag_q      <= '0;
      outst_q    <= '0;
      done_q     <= 1'b0;
      td_q       <= '0;
      trem_q     <= TREM_BOTH;
      sof_n_q    <= 1'b1;
      eof_n_q    <= 1'b1;
      src_n_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      cur_addr_q <= cur_addr_d;
      rem_dw_q   <= rem_dw_d;
      chunk_dw_q <= chunk_dw_d;
      tag_q      <= tag_d;
      outst_q    <= outst_d;
      done_q     <= done_d;
      td_q       <= td_d;
      trem_q     <= trem_d;
      sof_n_q    <= sof_n_d;
      eof_n_q    <= eof_n_d;
      src_n_q    <= src_n_d;
    end
  end

  // A completion for more DWs than are outstanding points to a bookkeeping
  // error upstream.
  assert property (@(posedge clk) disable iff (!rst_n) !(cpl_rcved && out_underflow));

  assign rd_lbuf_done   = done_q;
  assign trn_td         = td_q;
  assign trn_trem_n     = trem_q;
  assign trn_tsof_n     = sof_n_q;
  assign trn_teof_n     = eof_n_q;
  assign trn_tsrc_rdy_n = src_n_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_lbuf_mrd_req.sv
module tb_lbuf_mrd_req;
  import lbuf_mrd_req_pkg::*;

  localparam int          W   = 74;  // {td, trem_n, sof_n, eof_n}
  localparam logic [15:0] CID = 16'h0A18;

  typedef struct {
    logic [63:0] addr;
    int          len_qw;
    int          mrrs;
    int          mode;      // 0 ready, 1 toggle, 2 random
    int          exp_tlps;
  } vec_t;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        rd_lbuf = 1'b0;
  logic [63:0] lbuf_addr = '0;
  logic [31:0] lbuf_len = '0;
  logic        rd_lbuf_done;
  logic        cpl_rcved = 1'b0;
  logic [9:0]  cpl_dws = '0;
  logic [15:0] cfg_completer_id = CID;
  logic [2:0]  cfg_max_rd_req_size = 3'd2;
  logic [3:0]  trn_tbuf_av = 4'hF;
  logic        trn_tdst_rdy_n = 1'b0;
  logic [63:0] trn_td;
  logic [7:0]  trn_trem_n;
  logic        trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n;
  state_e      dbg_state;

  always #5 clk = ~clk;

  lbuf_mrd_req dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .rd_lbuf             (rd_lbuf),
    .lbuf_addr           (lbuf_addr),
    .lbuf_len            (lbuf_len),
    .rd_lbuf_done        (rd_lbuf_done),
    .cpl_rcved           (cpl_rcved),
    .cpl_dws             (cpl_dws),
    .cfg_completer_id    (cfg_completer_id),
    .cfg_max_rd_req_size (cfg_max_rd_req_size),
    .trn_tbuf_av         (trn_tbuf_av),
    .trn_tdst_rdy_n      (trn_tdst_rdy_n),
    .trn_td              (trn_td),
    .trn_trem_n          (trn_trem_n),
    .trn_tsof_n          (trn_tsof_n),
    .trn_teof_n          (trn_teof_n),
    .trn_tsrc_rdy_n      (trn_tsrc_rdy_n),
    .dbg_state           (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int             n_tests = 0;
  int             n_fail = 0;
  logic [W-1:0]   exp_q[$];
  int             cpl_q[$];
  int             tlp_cnt = 0;
  int             done_cycles = 0;
  int             inject_at = -1;
  bit             auto_cpl = 1'b1;
  int             tag_m = 0;
  logic [9:0]     cur_len = '0;
  logic [W-1:0]   held = '0;
  bit             held_v = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected beats for an lbuf pull: at most max_tlps TLPs, starting at tag_m.
  task automatic push_lbuf(input logic [63:0] addr, input int len_qw, input int mrrs,
                           input int max_tlps, output int n);
    longint      rem;
    logic [63:0] a;
    int          eff_dw, bnd, c;
    logic [31:0] dw0, dw1;
    logic [9:0]  len10;
    logic [4:0]  t5;
    bit          four;
    rem = longint'(len_qw) * 2;
    a   = addr;
    n   = 0;
    eff_dw = (mrrs > 5) ? 1024 : (32 << mrrs);
    if (eff_dw > 128) eff_dw = 128;
    while (rem > 0 && n < max_tlps) begin
      bnd = (4096 - int'(a[11:0])) / 4;
      c = eff_dw;
      if (rem < longint'(c)) c = int'(rem);
      if (bnd < c) c = bnd;
      four  = (a[63:32] != 32'h0);
      len10 = 10'(c);
      t5    = 5'(tag_m);
      dw0 = {1'b0, (four ? 2'b01 : 2'b00), 5'b00000, 1'b0, 3'b000, 4'b0000,
             1'b0, 1'b0, 2'b00, 2'b00, len10};
      dw1 = {CID, 3'b000, t5, 4'hF, 4'hF};
      exp_q.push_back({dw0, dw1, 8'h00, 1'b0, 1'b1});
      if (four) exp_q.push_back({a[63:32], a[31:2], 2'b00, 8'h00, 1'b1, 1'b0});
      else      exp_q.push_back({a[31:2], 2'b00, 32'h0, 8'h0F, 1'b1, 1'b0});
      a = a + 64'(c * 4);
      rem -= longint'(c);
      tag_m = (tag_m + 1) % 32;
      n++;
    end
  endtask

  // ---------------- monitor + completion driver (negedge sampling) ----------------
  always @(negedge clk) begin : mon
    logic [W-1:0] act;
    act = {trn_td, trn_trem_n, trn_tsof_n, trn_teof_n};
    cpl_rcved = 1'b0;
    if (!rst_n) begin
      held_v = 1'b0;
    end else begin
      if (rd_lbuf_done) done_cycles++;
      if (!trn_tsrc_rdy_n) begin
        if (held_v) check("hold_stable", 128'(act), 128'(held));
        if (trn_tdst_rdy_n) begin
          held   = act;
          held_v = 1'b1;
        end else begin
          held_v = 1'b0;
          if (exp_q.size() == 0) check("unexpected_beat", 128'(act), 128'(0));
          else                   check("beat", 128'(act), 128'(exp_q.pop_front()));
          if (!trn_tsof_n) cur_len = trn_td[41:32];
          if (!trn_teof_n) begin
            tlp_cnt++;
            if (tlp_cnt == inject_at) begin
              cpl_rcved = 1'b1;
              cpl_dws   = cur_len;
            end
            if (auto_cpl) cpl_q.push_back(int'(cur_len));
          end
        end
      end else begin
        held_v = 1'b0;
      end
      if (!cpl_rcved && cpl_q.size() > 0) begin
        cpl_rcved = 1'b1;
        cpl_dws   = 10'(cpl_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int mode);
    @(posedge clk);
    #1;
    case (mode)
      0: trn_tdst_rdy_n = 1'b0;
      1: trn_tdst_rdy_n = ~trn_tdst_rdy_n;
      2: trn_tdst_rdy_n = 1'($urandom_range(0, 1));
      default: ;
    endcase
  endtask

  task automatic wait_done(input int mode, input int budget);
    for (int i = 0; i < budget && !rd_lbuf_done; i++) tick(mode);
    check("done_reached", 128'(rd_lbuf_done), 128'(1));
  endtask

  task automatic wait_tlps(input int n, input int budget);
    for (int i = 0; i < budget && tlp_cnt < n; i++) tick(0);
    check("tlps_reached", 128'(tlp_cnt), 128'(n));
  endtask

  task automatic wait_src(input int budget);
    for (int i = 0; i < budget && trn_tsrc_rdy_n; i++) tick(3);
    check("src_rdy_reached", 128'(trn_tsrc_rdy_n), 128'(0));
  endtask

  task automatic drain_cpl();
    for (int i = 0; i < 500 && cpl_q.size() > 0; i++) tick(0);
    tick(0);
    tick(0);
  endtask

  task automatic start_lbuf(input logic [63:0] addr, input int len_qw, input int mrrs);
    cfg_max_rd_req_size = 3'(mrrs);
    lbuf_addr = addr;
    lbuf_len  = 32'(len_qw);
    rd_lbuf   = 1'b1;
  endtask

  task automatic run_entry(input vec_t v);
    int n;
    tlp_cnt = 0;
    push_lbuf(v.addr, v.len_qw, v.mrrs, 1000, n);
    start_lbuf(v.addr, v.len_qw, v.mrrs);
    wait_done(v.mode, 3000);
    check("tlp_count", 128'(tlp_cnt), 128'(v.exp_tlps));
    check("sb_empty", 128'(exp_q.size()), 128'(0));
    rd_lbuf = 1'b0;
    tick(0);
    tick(0);
    check("done_cleared", 128'(rd_lbuf_done), 128'(0));
    drain_cpl();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_td"},    128'(trn_td),         128'(0));
    check({tag, "_trem"},  128'(trn_trem_n),     128'(0));
    check({tag, "_sof"},   128'(trn_tsof_n),     128'(1));
    check({tag, "_eof"},   128'(trn_teof_n),     128'(1));
    check({tag, "_src"},   128'(trn_tsrc_rdy_n), 128'(1));
    check({tag, "_done"},  128'(rd_lbuf_done),   128'(0));
    check({tag, "_state"}, 128'(dbg_state),      128'(ST_IDLE));
  endtask

  // ---------------- test sequence ----------------
  vec_t vecs[7];

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int n, dc0;
    vecs[0] = '{64'h0000_0001_0000_0000,   64, 2, 0,  1};
    vecs[1] = '{64'h0000_0000_0000_2000,  256, 0, 0, 16};
    vecs[2] = '{64'h0000_0000_FFFF_F000, 1024, 2, 2, 16};
    vecs[3] = '{64'h0000_0000_0000_3000,   32, 1, 1,  1};
    vecs[4] = '{64'h0000_0007_0000_5000,   48, 5, 0,  1};
    vecs[5] = '{64'h0000_0000_0000_4000,  128, 2, 1,  2};
    vecs[6] = '{64'h0000_0000_0001_0000,  640, 0, 2, 40};

    // reset
    #3 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    tick(0);

    // table-driven lbuf pulls with auto completions
    auto_cpl = 1'b1;
    foreach (vecs[i]) run_entry(vecs[i]);

    // credit budget: stall at 1024 DW, release by completions, same-cycle net
    auto_cpl = 1'b0;
    tlp_cnt  = 0;
    push_lbuf(64'h0002_0000, 1024, 2, 1000, n);
    start_lbuf(64'h0002_0000, 1024, 2);
    wait_tlps(8, 500);
    repeat (20) tick(0);
    check("stall_at_budget", 128'(tlp_cnt), 128'(8));
    cpl_q.push_back(128);
    repeat (20) tick(0);
    check("ninth_after_cpl", 128'(tlp_cnt), 128'(9));
    inject_at = 10;
    cpl_q.push_back(128);
    repeat (30) tick(0);
    check("net_same_cycle", 128'(tlp_cnt), 128'(11));
    inject_at = -1;
    auto_cpl  = 1'b1;
    repeat (8) cpl_q.push_back(128);
    wait_done(0, 3000);
    check("budget_tlp_count", 128'(tlp_cnt), 128'(16));
    check("budget_sb_empty", 128'(exp_q.size()), 128'(0));
    rd_lbuf = 1'b0;
    tick(0);
    drain_cpl();

    // rd_lbuf withdrawn while the first beat is held: TLP completes, no done
    trn_tdst_rdy_n = 1'b1;
    tlp_cnt = 0;
    dc0 = done_cycles;
    push_lbuf(64'h0003_0000, 1024, 2, 1, n);
    start_lbuf(64'h0003_0000, 1024, 2);
    wait_src(100);
    rd_lbuf = 1'b0;
    repeat (30) tick(0);
    check("drop_tlp_count", 128'(tlp_cnt), 128'(1));
    check("drop_no_done", 128'(done_cycles), 128'(dc0));
    check("drop_state_idle", 128'(dbg_state), 128'(ST_IDLE));
    check("drop_sb_empty", 128'(exp_q.size()), 128'(0));
    drain_cpl();

    // reset in the middle of the second beat
    trn_tdst_rdy_n = 1'b1;
    push_lbuf(64'h0000_5000, 64, 2, 1, n);
    start_lbuf(64'h0000_5000, 64, 2);
    wait_src(100);
    tick(0);
    tick(3);
    trn_tdst_rdy_n = 1'b1;
    check("hdr1_eof", 128'(trn_teof_n), 128'(0));
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("midtlp_reset");
    rd_lbuf = 1'b0;
    exp_q.delete();
    tag_m = 0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick(0);

    // after reset the tag restarts at 0
    run_entry(vecs[0]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
